// File: rtl/alu_defs.sv
// alu_defs: shared encodings for the conditional execute unit.
//   op_e    : operation select (ADD, NAND, MUL, reserved)
//   cz_e    : condition / carry-in select
//   state_e : execute-unit FSM states
//   cond_pass() : condition check against the architectural C/Z flags
package alu_defs;

   typedef enum logic [1:0] {
      OP_ADD  = 2'b00,
      OP_NAND = 2'b01,
      OP_MUL  = 2'b10,
      OP_RSVD = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      CZ_NONE = 2'b00,
      CZ_IFZ  = 2'b01,
      CZ_IFC  = 2'b10,
      CZ_AWC  = 2'b11
   } cz_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_MUL  = 2'b10,
      ST_DONE = 2'b11
   } state_e;

   // AWC and unconditional forms always pass; only the C/Z-gated forms can fail.
   function automatic logic cond_pass(input cz_e cz, input logic c, input logic z);
      case (cz)
         CZ_IFC:  return c;
         CZ_IFZ:  return z;
         default: return 1'b1;
      endcase
   endfunction

endpackage

// File: rtl/seq_mul.sv
// seq_mul: shift-add multiplier, one multiplier bit consumed per step.
//   clk, reset : clock, asynchronous active-high reset
//   load       : capture a/b, clear accumulator and step counter
//   step       : perform one shift-add iteration
//   a, b       : multiplicand / multiplier
//   acc_next   : accumulator value after the current step (low WIDTH bits)
//   last       : current step is the final (WIDTH-th) iteration
module seq_mul #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] acc_next,
   output logic             last
);

   localparam int CW = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand_q, mcand_d;
   logic [WIDTH-1:0] mplier_q, mplier_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   // Exposing the post-step sum lets the caller latch the product on the final step.
   assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign last     = (cnt_q == CW'(WIDTH - 1));

   always_comb begin
      mcand_d  = mcand_q;
      mplier_d = mplier_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      if (load) begin
         mcand_d  = a;
         mplier_d = b;
         acc_d    = '0;
         cnt_d    = '0;
      end else if (step) begin
         mcand_d  = mcand_q << 1;
         mplier_d = mplier_q >> 1;
         acc_d    = acc_next;
         cnt_d    = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
      end else begin
         mcand_q  <= mcand_d;
         mplier_q <= mplier_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
      end
   end

endmodule

// File: rtl/cond_alu_unit.sv
// cond_alu_unit: multi-cycle execute unit with conditional ADD/NAND and MUL.
//   clk, reset : clock, asynchronous active-high reset
//   start      : request, sampled only in IDLE
//   op, cz     : operation / condition select (see alu_defs)
//   compl      : use ~srcb for ADD/NAND
//   srca, srcb : operands, latched at the accepting edge
//   busy       : high in every state except IDLE
//   done       : single-cycle completion pulse
//   wr_en      : with done, 1 = result is to be written back
//   result     : registered result, held until the next successful write
//   carry, zero: architectural C and Z flags
import alu_defs::*;

module cond_alu_unit #(
   parameter int WIDTH  = 16,
   parameter bit MUL_EN = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [1:0]       cz,
   input  logic             compl,
   input  logic [WIDTH-1:0] srca,
   input  logic [WIDTH-1:0] srcb,
   output logic             busy,
   output logic             done,
   output logic             wr_en,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             zero
);

   state_e           state_q, state_d;
   op_e              op_q, op_d;
   cz_e              cz_q, cz_d;
   logic             compl_q, compl_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             ok_q, ok_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             wr_en_q, wr_en_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             carry_q, carry_d;
   logic             zero_q, zero_d;

   logic             mul_load, mul_step, mul_last;
   logic [WIDTH-1:0] mul_next;
   logic [WIDTH-1:0] bop, nand_s;
   logic [WIDTH:0]   sum;
   logic             cin;

   generate
      if (MUL_EN) begin : g_mul
         seq_mul #(.WIDTH(WIDTH)) u_mul (
            .clk      (clk),
            .reset    (reset),
            .load     (mul_load),
            .step     (mul_step),
            .a        (a_d),
            .b        (b_d),
            .acc_next (mul_next),
            .last     (mul_last)
         );
      end else begin : g_no_mul
         assign mul_next = '0;
         assign mul_last = 1'b0;
      end
   endgenerate

   // Flags cannot change while busy, so reading carry_q here equals the accept-edge value.
   assign cin    = (cz_q == CZ_AWC) & carry_q;
   assign bop    = compl_q ? ~b_q : b_q;
   assign sum    = {1'b0, a_q} + {1'b0, bop} + {{WIDTH{1'b0}}, cin};
   assign nand_s = ~(a_q & bop);

   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      cz_d     = cz_q;
      compl_d  = compl_q;
      a_d      = a_q;
      b_d      = b_q;
      ok_d     = ok_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      wr_en_d  = 1'b0;
      result_d = result_q;
      carry_d  = carry_q;
      zero_d   = zero_q;
      mul_load = 1'b0;
      mul_step = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               op_d    = op_e'(op);
               cz_d    = cz_e'(cz);
               compl_d = compl;
               a_d     = srca;
               b_d     = srcb;
               ok_d    = (op_e'(op) == OP_MUL) | cond_pass(cz_e'(cz), carry_q, zero_q);
               busy_d  = 1'b1;
               if (op_e'(op) == OP_MUL && MUL_EN) begin
                  state_d  = ST_MUL;
                  mul_load = 1'b1;
               end else begin
                  state_d  = ST_EXEC;
               end
            end
         end
         ST_EXEC: begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            if (ok_q) begin
               case (op_q)
                  OP_ADD: begin
                     wr_en_d  = 1'b1;
                     result_d = sum[WIDTH-1:0];
                     carry_d  = sum[WIDTH];
                     zero_d   = (sum[WIDTH-1:0] == '0);
                  end
                  OP_NAND: begin
                     wr_en_d  = 1'b1;
                     result_d = nand_s;
                     zero_d   = (nand_s == '0);
                  end
                  default: ; // reserved, or MUL when not built
               endcase
            end
         end
         ST_MUL: begin
            mul_step = 1'b1;
            if (mul_last) begin
               state_d  = ST_DONE;
               done_d   = 1'b1;
               wr_en_d  = 1'b1;
               result_d = mul_next;
               zero_d   = (mul_next == '0);
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         op_q     <= OP_ADD;
         cz_q     <= CZ_NONE;
         compl_q  <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         ok_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         wr_en_q  <= 1'b0;
         result_q <= '0;
         carry_q  <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         cz_q     <= cz_d;
         compl_q  <= compl_d;
         a_q      <= a_d;
         b_q      <= b_d;
         ok_q     <= ok_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         wr_en_q  <= wr_en_d;
         result_q <= result_d;
         carry_q  <= carry_d;
         zero_q   <= zero_d;
      end
   end

   assign busy   = busy_q;
   assign done   = done_q;
   assign wr_en  = wr_en_q;
   assign result = result_q;
   assign carry  = carry_q;
   assign zero   = zero_q;

endmodule

// File: tb/tb_cond_alu_unit.sv
// Scoreboard bench for cond_alu_unit (WIDTH=16, MUL_EN=1).
module tb_cond_alu_unit;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [1:0]  cz;
   logic        compl;
   logic [15:0] srca;
   logic [15:0] srcb;
   logic        busy;
   logic        done;
   logic        wr_en;
   logic [15:0] result;
   logic        carry;
   logic        zero;

   cond_alu_unit #(.WIDTH(16), .MUL_EN(1'b1)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .cz     (cz),
      .compl  (compl),
      .srca   (srca),
      .srcb   (srcb),
      .busy   (busy),
      .done   (done),
      .wr_en  (wr_en),
      .result (result),
      .carry  (carry),
      .zero   (zero)
   );

   typedef struct {
      string       nm;
      logic [15:0] res;
      logic        wr;
      logic        c;
      logic        z;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;
   int   cycle = 0;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cycle <= cycle + 1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Monitor: every done pulse is matched against the oldest expectation.
   always @(negedge clk) begin
      if (!reset) begin
         if (done) begin
            if (sb.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL unexpected_done: got done=1 expected no completion (result 0x%0h)", result);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk({e.nm, ".result"}, 32'(result), 32'(e.res));
               chk({e.nm, ".wr_en"},  32'(wr_en),  32'(e.wr));
               chk({e.nm, ".carry"},  32'(carry),  32'(e.c));
               chk({e.nm, ".zero"},   32'(zero),   32'(e.z));
               chk({e.nm, ".latency"}, 32'(cycle - e.acc + 1), 32'(e.lat));
            end
         end else if (wr_en) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wr_en_without_done: got wr_en=1 expected 0");
         end
      end
   end

   task automatic issue(input string nm, input logic [1:0] o, input logic [1:0] c,
                        input logic cp, input logic [15:0] a, input logic [15:0] b,
                        input bit push, input logic [15:0] er, input logic ew,
                        input logic ec, input logic ez, input int lat);
      int n;
      n = 0;
      while (busy && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         n_cmp++;
         n_bad++;
         $display("FAIL %s.wait_idle: got busy=1 expected 0 within 200 cycles", nm);
      end
      op    = o;
      cz    = c;
      compl = cp;
      srca  = a;
      srcb  = b;
      start = 1'b1;
      if (push) sb.push_back('{nm, er, ew, ec, ez, lat, cycle + 1});
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      cz    = 2'b00;
      compl = 1'b0;
      srca  = '0;
      srcb  = '0;
      @(negedge clk);
      chk("rst.busy",   32'(busy),   32'd0);
      chk("rst.done",   32'(done),   32'd0);
      chk("rst.wr_en",  32'(wr_en),  32'd0);
      chk("rst.result", 32'(result), 32'd0);
      chk("rst.carry",  32'(carry),  32'd0);
      chk("rst.zero",   32'(zero),   32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      //     name        op     cz     cp    A         B        push  res       wr    C     Z     lat
      issue("add1",     2'b00, 2'b00, 1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 2);
      issue("add_ovf",  2'b00, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 2);
      issue("adc_ok",   2'b00, 2'b10, 1'b0, 16'h0002, 16'h0004, 1'b1, 16'h0006, 1'b1, 1'b0, 1'b0, 2);
      issue("adc_skip", 2'b00, 2'b10, 1'b0, 16'h0002, 16'h0004, 1'b1, 16'h0006, 1'b0, 1'b0, 1'b0, 2);
      issue("add_ovf2", 2'b00, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 2);
      issue("awc",      2'b00, 2'b11, 1'b0, 16'h0007, 16'h0001, 1'b1, 16'h0009, 1'b1, 1'b0, 1'b0, 2);
      issue("add_ovf3", 2'b00, 2'b00, 1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 2);
      issue("awc_cpl",  2'b00, 2'b11, 1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 2);
      issue("add_cpl",  2'b00, 2'b00, 1'b1, 16'h0005, 16'h0003, 1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 2);
      issue("nand_z",   2'b01, 2'b00, 1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 2);
      issue("ndz_ok",   2'b01, 2'b01, 1'b0, 16'h00F0, 16'h0FF0, 1'b1, 16'hFF0F, 1'b1, 1'b1, 1'b0, 2);
      issue("ndz_skip", 2'b01, 2'b01, 1'b0, 16'h1111, 16'h2222, 1'b1, 16'hFF0F, 1'b0, 1'b1, 1'b0, 2);
      issue("add_clrc", 2'b00, 2'b00, 1'b0, 16'h0001, 16'h0001, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 2);
      issue("ndc_skip", 2'b01, 2'b10, 1'b0, 16'h1234, 16'h5678, 1'b1, 16'h0002, 1'b0, 1'b0, 1'b0, 2);
      issue("nand_cz11",2'b01, 2'b11, 1'b1, 16'hFF00, 16'h00FF, 1'b1, 16'h00FF, 1'b1, 1'b0, 1'b0, 2);
      issue("reserved", 2'b11, 2'b00, 1'b0, 16'h0001, 16'h0001, 1'b1, 16'h00FF, 1'b0, 1'b0, 1'b0, 2);

      // MUL with busy held and a stray start mid-operation that must be ignored.
      issue("mul1",     2'b10, 2'b00, 1'b0, 16'h0012, 16'h0010, 1'b1, 16'h0120, 1'b1, 1'b0, 1'b0, 17);
      for (int i = 0; i < 15; i++) begin
         chk("mul1.busy", 32'(busy), 32'd1);
         if (i == 4) begin
            op    = 2'b00;
            cz    = 2'b00;
            srca  = 16'h1111;
            srcb  = 16'h1111;
            start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
      end
      start = 1'b0;
      // cz=10 with C=0 must not gate MUL.
      issue("mul_wrap", 2'b10, 2'b10, 1'b1, 16'h8000, 16'h0002, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 17);

      // Abort a MUL with reset during its fifth cycle; no completion may follow.
      issue("mul_abort",2'b10, 2'b00, 1'b0, 16'h0003, 16'h0005, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 17);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("abort.busy",   32'(busy),   32'd0);
      chk("abort.done",   32'(done),   32'd0);
      chk("abort.wr_en",  32'(wr_en),  32'd0);
      chk("abort.result", 32'(result), 32'd0);
      chk("abort.carry",  32'(carry),  32'd0);
      chk("abort.zero",   32'(zero),   32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      issue("add_after",2'b00, 2'b00, 1'b0, 16'h0005, 16'h0003, 1'b1, 16'h0008, 1'b1, 1'b0, 1'b0, 2);

      n = 0;
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: got %0d pending completions expected 0", sb.size());
      end
      repeat (20) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
